// File: rtl/qbus_dma_arb_if.sv
// rtl/qbus_dma_arb_if.sv - Qbus mastership arbiter signal bundle
interface qbus_dma_arb_if;
    logic pin_init;
    logic pin_dmr;
    logic pin_sack;
    logic pin_sync;
    logic cpu_req;
    logic cpu_gnt;
    logic pin_dmgo;
    logic dma_act;
    logic dma_tmo;

    modport master (
        output pin_init, pin_dmr, pin_sack, pin_sync, cpu_req,
        input  cpu_gnt, pin_dmgo, dma_act, dma_tmo
    );

    modport slave (
        input  pin_init, pin_dmr, pin_sack, pin_sync, cpu_req,
        output cpu_gnt, pin_dmgo, dma_act, dma_tmo
    );
endinterface

// File: rtl/qbus_dma_arb.sv
// rtl/qbus_dma_arb.sv - Qbus bus-mastership arbiter between core and DMA masters
module qbus_dma_arb #(
    parameter int TMO_W    = 8,
    parameter int TMO_CNT  = 200,
    parameter int CPU_FAIR = 1
) (
    input  logic            pin_clk,
    input  logic            pin_dclo_n,
    qbus_dma_arb_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU,
        S_GRANT,
        S_DMA,
        S_RELEASE
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CNT - 1);
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             fair;

    // Outputs are registered from the next state, so every branch that keeps
    // or enters a state re-asserts that state's output; the rest default low.
    always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            fair         <= 1'b0;
            bus.cpu_gnt  <= 1'b0;
            bus.pin_dmgo <= 1'b0;
            bus.dma_act  <= 1'b0;
            bus.dma_tmo  <= 1'b0;
        end else begin
            bus.cpu_gnt  <= 1'b0;
            bus.pin_dmgo <= 1'b0;
            bus.dma_act  <= 1'b0;
            bus.dma_tmo  <= 1'b0;
            if (bus.pin_init) begin
                state   <= S_IDLE;
                tmo_cnt <= '0;
                fair    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.pin_dmr && !bus.pin_sync && !fair) begin
                            state        <= S_GRANT;
                            tmo_cnt      <= '0;
                            bus.pin_dmgo <= 1'b1;
                        end else if (bus.cpu_req) begin
                            state       <= S_CPU;
                            fair        <= 1'b0;
                            bus.cpu_gnt <= 1'b1;
                        end else begin
                            fair <= 1'b0;
                        end
                    end
                    // DMR is deliberately ignored until the core's cycle finishes.
                    S_CPU: begin
                        if (bus.cpu_req || bus.pin_sync) begin
                            bus.cpu_gnt <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_GRANT: begin
                        if (bus.pin_sack) begin
                            state       <= S_DMA;
                            tmo_cnt     <= '0;
                            bus.dma_act <= 1'b1;
                        end else if (!bus.pin_dmr) begin
                            state   <= S_IDLE;
                            tmo_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state       <= S_IDLE;
                            tmo_cnt     <= '0;
                            bus.dma_tmo <= 1'b1;
                        end else begin
                            bus.pin_dmgo <= 1'b1;
                            if (tmo_cnt != CNT_MAX) begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
                    end
                    S_DMA: begin
                        if (!bus.pin_sack && !bus.pin_sync) begin
                            state <= S_RELEASE;
                        end else begin
                            bus.dma_act <= 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        state <= S_IDLE;
                        if (CPU_FAIR != 0 && bus.cpu_req) begin
                            fair <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        tmo_cnt <= '0;
                        fair    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb/tb_qbus_dma_arb.sv - directed self-checking bench for qbus_dma_arb
module tb_qbus_dma_arb;

    logic pin_clk = 1'b0;
    logic pin_dclo_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 pin_clk = ~pin_clk;

    qbus_dma_arb_if bus ();
    qbus_dma_arb_if bus_nf ();

    assign bus_nf.pin_init = bus.pin_init;
    assign bus_nf.pin_dmr  = bus.pin_dmr;
    assign bus_nf.pin_sack = bus.pin_sack;
    assign bus_nf.pin_sync = bus.pin_sync;
    assign bus_nf.cpu_req  = bus.cpu_req;

    qbus_dma_arb #(.TMO_W(8), .TMO_CNT(200), .CPU_FAIR(1)) u_dut (
        .pin_clk    (pin_clk),
        .pin_dclo_n (pin_dclo_n),
        .bus        (bus.slave)
    );

    qbus_dma_arb #(.TMO_W(8), .TMO_CNT(200), .CPU_FAIR(0)) u_dut_nf (
        .pin_clk    (pin_clk),
        .pin_dclo_n (pin_dclo_n),
        .bus        (bus_nf.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {cpu_gnt, pin_dmgo, dma_act, dma_tmo}
    function automatic int outs();
        return int'({bus.cpu_gnt, bus.pin_dmgo, bus.dma_act, bus.dma_tmo});
    endfunction

    function automatic int outs_nf();
        return int'({bus_nf.cpu_gnt, bus_nf.pin_dmgo, bus_nf.dma_act, bus_nf.dma_tmo});
    endfunction

    task automatic tick();
        @(posedge pin_clk);
        #1;
    endtask

    // Counts cycles pin_dmgo stays high, starting on a cycle where it is high.
    task automatic grant_len(output int len);
        len = 0;
        while (bus.pin_dmgo && len < 400) begin
            len++;
            tick();
        end
    endtask

    always @(negedge pin_clk) begin
        check("excl_gnt_dmgo", int'(bus.cpu_gnt & (bus.pin_dmgo | bus.dma_act)), 0);
        check("excl_nf", int'(bus_nf.cpu_gnt & (bus_nf.pin_dmgo | bus_nf.dma_act)), 0);
    end

    initial begin
        int len;
        bus.pin_init = 1'b0;
        bus.pin_dmr  = 1'b0;
        bus.pin_sack = 1'b0;
        bus.pin_sync = 1'b0;
        bus.cpu_req  = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 4'b0000);
        pin_dclo_n = 1'b1;
        tick();
        check("idle_outs", outs(), 4'b0000);

        // Basic DMA tenure
        bus.pin_dmr = 1'b1;
        tick();  check("grant", outs(), 4'b0100);
        tick();  check("grant_hold", outs(), 4'b0100);
        bus.pin_sack = 1'b1; bus.pin_sync = 1'b1;
        tick();  check("dma", outs(), 4'b0010);
        bus.pin_sack = 1'b0;
        tick();  check("dma_sync_hold", outs(), 4'b0010);
        bus.pin_dmr = 1'b0; bus.pin_sync = 1'b0;
        tick();  check("release", outs(), 4'b0000);
        tick();  check("release_idle", outs(), 4'b0000);

        // Spurious SACK in IDLE
        bus.pin_sack = 1'b1;
        tick();  check("sack_idle", outs(), 4'b0000);
        bus.pin_sack = 1'b0;

        // Core cycle holds off a DMR
        bus.cpu_req = 1'b1;
        tick();  check("cpu", outs(), 4'b1000);
        bus.pin_sync = 1'b1; bus.pin_dmr = 1'b1;
        tick();  check("cpu_dmr_ign", outs(), 4'b1000);
        bus.cpu_req = 1'b0;
        tick();  check("cpu_sync_hold", outs(), 4'b1000);
        bus.pin_sync = 1'b0;
        tick();  check("cpu_end", outs(), 4'b0000);
        tick();  check("grant_after_cpu", outs(), 4'b0100);
        bus.pin_dmr = 1'b0;
        tick();  check("withdraw", outs(), 4'b0000);

        // Spurious SACK during a core cycle
        bus.cpu_req = 1'b1;
        tick();  check("cpu2", outs(), 4'b1000);
        bus.pin_sack = 1'b1;
        tick();  check("sack_cpu", outs(), 4'b1000);
        bus.cpu_req = 1'b0; bus.pin_sack = 1'b0;
        tick();  check("cpu2_end", outs(), 4'b0000);

        // Grant timeout and re-grant
        bus.pin_dmr = 1'b1;
        tick();
        grant_len(len);
        check("tmo_len", len, 200);
        check("tmo_pulse", outs(), 4'b0001);
        tick();  check("regrant", outs(), 4'b0100);
        bus.pin_dmr = 1'b0;
        tick();  check("regrant_drop", outs(), 4'b0000);

        // Fairness: CPU_FAIR=1 serves core first, CPU_FAIR=0 grants again
        bus.cpu_req = 1'b1; bus.pin_dmr = 1'b1;
        tick();  check("f_grant", outs(), 4'b0100); check("nf_grant", outs_nf(), 4'b0100);
        bus.pin_sack = 1'b1; bus.pin_sync = 1'b1;
        tick();  check("f_dma", outs(), 4'b0010); check("nf_dma", outs_nf(), 4'b0010);
        bus.pin_sack = 1'b0; bus.pin_sync = 1'b0;
        tick();  check("f_rel", outs(), 4'b0000); check("nf_rel", outs_nf(), 4'b0000);
        tick();  check("f_idle", outs(), 4'b0000); check("nf_idle", outs_nf(), 4'b0000);
        tick();  check("f_cpu", outs(), 4'b1000); check("nf_grant2", outs_nf(), 4'b0100);
        bus.cpu_req = 1'b0;
        tick();  check("f_cpu_end", outs(), 4'b0000); check("nf_grant2_hold", outs_nf(), 4'b0100);
        tick();  check("f_grant2", outs(), 4'b0100);
        bus.pin_dmr = 1'b0;
        tick();  check("f_drop", outs(), 4'b0000); check("nf_drop", outs_nf(), 4'b0000);

        // pin_init during DMA and during GRANT
        bus.pin_dmr = 1'b1;
        tick();  check("i_grant", outs(), 4'b0100);
        bus.pin_sack = 1'b1; bus.pin_sync = 1'b1;
        tick();  check("i_dma", outs(), 4'b0010);
        bus.pin_init = 1'b1;
        tick();  check("init_dma", outs(), 4'b0000);
        tick();  check("init_hold", outs(), 4'b0000);
        bus.pin_sack = 1'b0; bus.pin_sync = 1'b0;
        tick();  check("init_no_grant", outs(), 4'b0000);
        bus.pin_init = 1'b0;
        tick();  check("init_rel_grant", outs(), 4'b0100);
        bus.pin_init = 1'b1;
        tick();  check("init_grant", outs(), 4'b0000);
        bus.pin_init = 1'b0;
        tick();  check("init_regrant", outs(), 4'b0100);
        bus.pin_dmr = 1'b0;
        tick();  check("init_drop", outs(), 4'b0000);

        // Asynchronous reset mid-GRANT, counter restarts
        bus.pin_dmr = 1'b1;
        tick();  check("r_grant", outs(), 4'b0100);
        repeat (5) tick();
        #2;
        pin_dclo_n = 1'b0;
        #1;
        check("async_rst", outs(), 4'b0000);
        #3;
        pin_dclo_n = 1'b1;
        #1;
        check("rst_idle", outs(), 4'b0000);
        tick();  check("r_regrant", outs(), 4'b0100);
        grant_len(len);
        check("r_tmo_len", len, 200);
        check("r_tmo_pulse", outs(), 4'b0001);
        bus.pin_dmr = 1'b0;
        tick();  check("r_end", outs(), 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
